// File: rtl/secuenciador_control.sv
// Microprogrammed control sequencer for the accumulator data unit.
// Runs C <= A + ITER*B - C (copy left in T) and reports completion on a four-phase xs/fin handshake.
module secuenciador_control #(
    parameter int ITER = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       xs,
    output logic       Ra,
    output logic       Rb,
    output logic       Rc,
    output logic       Rac,
    output logic       Wa,
    output logic       Wb,
    output logic       Wc,
    output logic       Wac,
    output logic       Wt,
    output logic       S,
    output logic       R,
    output logic       fin,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        ADD_B   = 3'd2,
        SUB_C   = 3'd3,
        SAVE_T  = 3'd4,
        STORE_C = 3'd5,
        DONE    = 3'd6
    } state_t;

    // Last ADD_B count; only consulted when ITER > 0, so the ITER = 0 value is a don't-care.
    localparam logic [3:0] ITER_LAST = (ITER > 0) ? 4'(ITER - 1) : 4'd0;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = IDLE;
        cnt_n   = cnt;
        Ra      = 1'b0;
        Rb      = 1'b0;
        Rc      = 1'b0;
        Rac     = 1'b0;
        Wc      = 1'b0;
        Wac     = 1'b0;
        Wt      = 1'b0;
        S       = 1'b0;
        R       = 1'b0;
        fin     = 1'b0;
        case (state)
            IDLE: begin
                if (xs) begin
                    state_n = LOAD_A;
                    cnt_n   = 4'd0;
                end else begin
                    state_n = IDLE;
                end
            end
            LOAD_A: begin
                Ra      = 1'b1;
                Wac     = 1'b1;
                state_n = (ITER > 0) ? ADD_B : SUB_C;
            end
            ADD_B: begin
                Rb    = 1'b1;
                S     = 1'b1;
                Wac   = 1'b1;
                cnt_n = cnt + 4'd1;
                if (cnt == ITER_LAST) state_n = SUB_C;
                else                  state_n = ADD_B;
            end
            SUB_C: begin
                Rc      = 1'b1;
                R       = 1'b1;
                Wac     = 1'b1;
                state_n = SAVE_T;
            end
            SAVE_T: begin
                Rac     = 1'b1;
                Wt      = 1'b1;
                state_n = STORE_C;
            end
            STORE_C: begin
                Rac     = 1'b1;
                Wc      = 1'b1;
                state_n = DONE;
            end
            DONE: begin
                fin     = 1'b1;
                // No re-trigger: xs must fall to 0 and rise again to start a new run.
                state_n = xs ? DONE : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign Wa        = 1'b0;
    assign Wb        = 1'b0;
    assign state_dbg = state;

endmodule

// File: tb/tb_secuenciador_control.sv
// Bench for secuenciador_control: ITER=2 and ITER=0 instances, each driving a small data-unit model.
module tb_secuenciador_control;

    // Output vector order: {Ra,Rb,Rc,Rac,Wa,Wb,Wc,Wac,Wt,S,R,fin}
    localparam logic [11:0] V_IDLE  = 12'b0000_0000_0000;
    localparam logic [11:0] V_LOAD  = 12'b1000_0001_0000;
    localparam logic [11:0] V_ADD   = 12'b0100_0001_0100;
    localparam logic [11:0] V_SUB   = 12'b0010_0001_0010;
    localparam logic [11:0] V_SAVE  = 12'b0001_0000_1000;
    localparam logic [11:0] V_STORE = 12'b0001_0010_0000;
    localparam logic [11:0] V_FIN   = 12'b0000_0000_0001;

    logic clk, reset, xs, xs0;
    logic Ra, Rb, Rc, Rac, Wa, Wb, Wc, Wac, Wt, S, R, fin;
    logic Ra0, Rb0, Rc0, Rac0, Wa0, Wb0, Wc0, Wac0, Wt0, S0, R0, fin0;
    logic [2:0] st2, st0;

    int errors = 0;
    int checks = 0;
    logic [11:0] exp_q[$];

    // Data-unit model inputs (loaded at an edge where the sequencer is idle)
    logic       ld;
    logic [7:0] ia, ib, ic;
    logic [7:0] a2, b2, c2, ac2, t2, bus2;
    logic [7:0] a0, b0, c0, ac0, t0, bus0;

    secuenciador_control #(.ITER(2)) dut2 (
        .clk(clk), .reset(reset), .xs(xs),
        .Ra(Ra), .Rb(Rb), .Rc(Rc), .Rac(Rac),
        .Wa(Wa), .Wb(Wb), .Wc(Wc), .Wac(Wac), .Wt(Wt),
        .S(S), .R(R), .fin(fin), .state_dbg(st2)
    );

    secuenciador_control #(.ITER(0)) dut0 (
        .clk(clk), .reset(reset), .xs(xs0),
        .Ra(Ra0), .Rb(Rb0), .Rc(Rc0), .Rac(Rac0),
        .Wa(Wa0), .Wb(Wb0), .Wc(Wc0), .Wac(Wac0), .Wt(Wt0),
        .S(S0), .R(R0), .fin(fin0), .state_dbg(st0)
    );

    wire [11:0] v2 = {Ra, Rb, Rc, Rac, Wa, Wb, Wc, Wac, Wt, S, R, fin};
    wire [11:0] v0 = {Ra0, Rb0, Rc0, Rac0, Wa0, Wb0, Wc0, Wac0, Wt0, S0, R0, fin0};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data-unit models
    always_comb begin
        bus2 = 8'd0;
        if (Ra)       bus2 = a2;
        else if (Rb)  bus2 = b2;
        else if (Rc)  bus2 = c2;
        else if (Rac) bus2 = ac2;
        bus0 = 8'd0;
        if (Ra0)       bus0 = a0;
        else if (Rb0)  bus0 = b0;
        else if (Rc0)  bus0 = c0;
        else if (Rac0) bus0 = ac0;
    end

    always @(posedge clk) begin
        if (ld) begin
            a2 <= ia; b2 <= ib; c2 <= ic;
            a0 <= ia; b0 <= ib; c0 <= ic;
        end else begin
            if (Wac) ac2 <= S ? ac2 + bus2 : (R ? ac2 - bus2 : bus2);
            if (Wt)  t2  <= bus2;
            if (Wc)  c2  <= bus2;
            if (Wac0) ac0 <= S0 ? ac0 + bus0 : (R0 ? ac0 - bus0 : bus0);
            if (Wt0)  t0  <= bus0;
            if (Wc0)  c0  <= bus0;
        end
    end

    // driver / checker tasks
    task automatic rules(input string tag, input logic [11:0] v);
        checks++;
        assert ($onehot0(v[11:8]) === 1'b1) else begin
            errors++; $error("FAIL %s read_onehot got=%b req=onehot0", tag, v[11:8]);
        end
        checks++;
        assert (((v[2] | v[1]) & ~v[4]) === 1'b0) else begin
            errors++; $error("FAIL %s alu_without_wac got=%b req=S/R only with Wac", tag, v);
        end
        checks++;
        assert ((v[2] & v[1]) === 1'b0) else begin
            errors++; $error("FAIL %s s_and_r got=%b req=exclusive", tag, v);
        end
        checks++;
        assert (v[7:6] === 2'b00) else begin
            errors++; $error("FAIL %s wa_wb got=%b req=00", tag, v[7:6]);
        end
        checks++;
        assert ((v[11:8] == 4'd0) || ($countones(v[7:3]) == 1)) else begin
            errors++; $error("FAIL %s one_write got=%b req=exactly one", tag, v[7:3]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        rules("dut2", v2);
        rules("dut0", v0);
    endtask

    task automatic cmp(input string tag, input logic [11:0] got, input logic [11:0] e);
        checks++;
        assert (got === e) else begin
            errors++; $error("FAIL %s got=%b req=%b", tag, got, e);
        end
    endtask

    task automatic cmp8(input string tag, input logic [7:0] got, input logic [7:0] e);
        checks++;
        assert (got === e) else begin
            errors++; $error("FAIL %s got=%0d req=%0d", tag, got, e);
        end
    endtask

    task automatic push_run(input int iter);
        exp_q.push_back(V_LOAD);
        for (int i = 0; i < iter; i++) exp_q.push_back(V_ADD);
        exp_q.push_back(V_SUB);
        exp_q.push_back(V_SAVE);
        exp_q.push_back(V_STORE);
        exp_q.push_back(V_FIN);
    endtask

    // Pops one expectation per cycle; xs of the selected DUT drops after drop_at cycles (0 = never).
    task automatic drain(input string tag, input int sel, input int drop_at);
        int n = 0;
        while (exp_q.size() > 0) begin
            logic [11:0] e;
            tick();
            ld = 1'b0;
            e = exp_q.pop_front();
            n++;
            cmp($sformatf("%s[%0d]", tag, n), (sel == 2) ? v2 : v0, e);
            if (n == drop_at) begin
                if (sel == 2) xs = 1'b0;
                else          xs0 = 1'b0;
            end
        end
    endtask

    initial begin
        reset = 1'b0; xs = 1'b1; xs0 = 1'b1; ld = 1'b0;
        ia = 8'd0; ib = 8'd0; ic = 8'd0;

        // Reset held with xs=1: everything quiet
        repeat (3) begin
            tick();
            cmp("reset_dut2", v2, V_IDLE);
            cmp("reset_dut0", v0, V_IDLE);
        end
        xs0 = 1'b0;

        // Default run ITER=2, xs held until fin, then held 20 more cycles
        ia = 8'd5; ib = 8'd3; ic = 8'd4; ld = 1'b1;
        reset = 1'b1;
        push_run(2);
        drain("run2", 2, 0);
        repeat (20) exp_q.push_back(V_FIN);
        drain("hold_fin", 2, 0);
        cmp8("run2_C", c2, 8'd7);
        cmp8("run2_T", t2, 8'd7);

        // Release: fin drops the next cycle and stays low
        xs = 1'b0;
        exp_q.push_back(V_IDLE);
        exp_q.push_back(V_IDLE);
        drain("release", 2, 0);

        // New start with a one-cycle xs pulse: full run, fin for one cycle, back to IDLE
        ia = 8'd1; ib = 8'd2; ic = 8'd3; ld = 1'b1;
        xs = 1'b1;
        push_run(2);
        exp_q.push_back(V_IDLE);
        exp_q.push_back(V_IDLE);
        drain("pulse", 2, 1);
        cmp8("pulse_C", c2, 8'd2);
        cmp8("pulse_T", t2, 8'd2);

        // ITER=0 instance
        ia = 8'd9; ib = 8'd7; ic = 8'd4; ld = 1'b1;
        xs0 = 1'b1;
        push_run(0);
        exp_q.push_back(V_IDLE);
        drain("run0", 0, 5);
        cmp8("run0_C", c0, 8'd5);
        cmp8("run0_T", t0, 8'd5);

        // Reset during the second ADD_B cycle
        ia = 8'd2; ib = 8'd5; ic = 8'd1; ld = 1'b1;
        xs = 1'b1;
        exp_q.push_back(V_LOAD);
        exp_q.push_back(V_ADD);
        exp_q.push_back(V_ADD);
        drain("pre_abort", 2, 1);
        reset = 1'b0;
        tick();
        cmp("abort", v2, V_IDLE);
        reset = 1'b1;
        repeat (4) begin
            tick();
            cmp("after_abort", v2, V_IDLE);
        end
        cmp8("abort_C_untouched", c2, 8'd1);

        // Clean sequence after abort: exactly two ADD_B cycles proves cnt restarted
        ia = 8'd3; ib = 8'd4; ic = 8'd5; ld = 1'b1;
        xs = 1'b1;
        push_run(2);
        exp_q.push_back(V_IDLE);
        drain("restart", 2, 1);
        cmp8("restart_C", c2, 8'd6);
        cmp8("restart_T", t2, 8'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
